// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//
// Write-back buffer in front of the register file's single write port.
// Results from the load unit (mem) and the ALU are accepted through
// valid/ready handshakes into a small in-order FIFO. One entry per cycle is
// drained into the registered write port. A combinational forwarding port
// returns the youngest pending value for any register address.
//
// Ports:
//   clk          clock, rising edge
//   resetN       synchronous active-low reset
//   memValid/memAdr/memData/memReady   load-unit result handshake
//   aluValid/aluAdr/aluData/aluReady   ALU result handshake
//   writeAdr/writeData/writeEnable     registered register-file write port
//   fwdAdr/fwdHit/fwdData              combinational forwarding lookup
//   count/full/empty                   FIFO occupancy (registered count)
// -----------------------------------------------------------------------------
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADR_W  = 6
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       memValid,
    input  logic [ADR_W-1:0]           memAdr,
    input  logic [DATA_W-1:0]          memData,
    output logic                       memReady,
    input  logic                       aluValid,
    input  logic [ADR_W-1:0]           aluAdr,
    input  logic [DATA_W-1:0]          aluData,
    output logic                       aluReady,
    output logic [ADR_W-1:0]           writeAdr,
    output logic [DATA_W-1:0]          writeData,
    output logic                       writeEnable,
    input  logic [ADR_W-1:0]           fwdAdr,
    output logic                       fwdHit,
    output logic [DATA_W-1:0]          fwdData,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage and pointers
    logic [ADR_W-1:0]  fifoAdr_reg  [DEPTH];
    logic [DATA_W-1:0] fifoData_reg [DEPTH];
    logic [PTR_W-1:0]  wrPtr_reg;
    logic [PTR_W-1:0]  rdPtr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              pushMem;
    logic              pushAlu;
    logic              popHead;
    logic [PTR_W-1:0]  aluSlot;

    // Readies look only at the registered count: a pop in this cycle does
    // not grant a slot until the next cycle. The ALU gets the last free slot
    // only when the load unit is not competing for it.
    assign memReady = resetN && (count_reg < CNT_W'(DEPTH));
    assign aluReady = resetN &&
                      ((count_reg <= CNT_W'(DEPTH - 2)) ||
                       ((count_reg == CNT_W'(DEPTH - 1)) && !memValid));

    assign pushMem = memValid && memReady;
    assign pushAlu = aluValid && aluReady;
    assign popHead = (count_reg != '0);

    // The mem entry is older, so the ALU entry lands one slot behind it
    assign aluSlot = wrPtr_reg + PTR_W'(pushMem);

    assign count = count_reg;
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Storage array carries no reset: stale contents are masked by count
    always_ff @(posedge clk) begin
        if (pushMem) begin
            fifoAdr_reg[wrPtr_reg]  <= memAdr;
            fifoData_reg[wrPtr_reg] <= memData;
        end
        if (pushAlu) begin
            fifoAdr_reg[aluSlot]  <= aluAdr;
            fifoData_reg[aluSlot] <= aluData;
        end
    end

    // Pointers, occupancy and the registered write port
    always_ff @(posedge clk) begin
        if (!resetN) begin
            wrPtr_reg   <= '0;
            rdPtr_reg   <= '0;
            count_reg   <= '0;
            writeEnable <= 1'b0;
            writeAdr    <= '0;
            writeData   <= '0;
        end else begin
            wrPtr_reg <= wrPtr_reg + PTR_W'(pushMem) + PTR_W'(pushAlu);
            count_reg <= count_reg + CNT_W'(pushMem) + CNT_W'(pushAlu)
                         - CNT_W'(popHead);
            if (popHead) begin
                rdPtr_reg   <= rdPtr_reg + PTR_W'(1);
                writeEnable <= 1'b1;
                writeAdr    <= fifoAdr_reg[rdPtr_reg];
                writeData   <= fifoData_reg[rdPtr_reg];
            end else begin
                // Address/data hold their last values when idle
                writeEnable <= 1'b0;
            end
        end
    end

    // Per-entry forwarding match, indexed by age (0 = oldest at the head)
    logic [DEPTH-1:0]  entryHit;
    logic [DATA_W-1:0] entryData [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PTR_W-1:0] idx;
        assign idx           = rdPtr_reg + PTR_W'(gi);
        assign entryHit[gi]  = (CNT_W'(gi) < count_reg) &&
                               (fifoAdr_reg[idx] == fwdAdr);
        assign entryData[gi] = fifoData_reg[idx];
    end

    // Lowest priority is the output stage; later (younger) FIFO matches
    // overwrite earlier ones, so the youngest pending value wins.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        if (writeEnable && (writeAdr == fwdAdr)) begin
            fwdHit  = 1'b1;
            fwdData = writeData;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (entryHit[i]) begin
                fwdHit  = 1'b1;
                fwdData = entryData[i];
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_writeback_queue
//
// Self-checking bench for writeback_queue: a table of directed per-cycle
// vectors, hand-written reset and fill sequences, and random dual-producer
// traffic against a queue/register-file model. A second DEPTH=2 instance
// exercises the full condition.
// -----------------------------------------------------------------------------
module tb_writeback_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- main DUT (DEPTH=4) ----------------
    logic        resetN = 1'b0;
    logic        memValid = 1'b0, aluValid = 1'b0;
    logic [5:0]  memAdr = '0, aluAdr = '0, fwdAdr = '0;
    logic [63:0] memData = '0, aluData = '0;
    logic        memReady, aluReady, writeEnable, fwdHit, full, empty;
    logic [5:0]  writeAdr;
    logic [63:0] writeData, fwdData;
    logic [2:0]  count;

    writeback_queue #(.DEPTH(4), .DATA_W(64), .ADR_W(6)) dut (
        .clk(clk), .resetN(resetN),
        .memValid(memValid), .memAdr(memAdr), .memData(memData), .memReady(memReady),
        .aluValid(aluValid), .aluAdr(aluAdr), .aluData(aluData), .aluReady(aluReady),
        .writeAdr(writeAdr), .writeData(writeData), .writeEnable(writeEnable),
        .fwdAdr(fwdAdr), .fwdHit(fwdHit), .fwdData(fwdData),
        .count(count), .full(full), .empty(empty)
    );

    // ---------------- small DUT (DEPTH=2) ----------------
    logic        sResetN = 1'b0;
    logic        sMemValid = 1'b0, sAluValid = 1'b0;
    logic [5:0]  sMemAdr = '0, sAluAdr = '0, sFwdAdr = '0;
    logic [63:0] sMemData = '0, sAluData = '0;
    logic        sMemReady, sAluReady, sWriteEnable, sFwdHit, sFull, sEmpty;
    logic [5:0]  sWriteAdr;
    logic [63:0] sWriteData, sFwdData;
    logic [1:0]  sCount;

    writeback_queue #(.DEPTH(2), .DATA_W(64), .ADR_W(6)) dut2 (
        .clk(clk), .resetN(sResetN),
        .memValid(sMemValid), .memAdr(sMemAdr), .memData(sMemData), .memReady(sMemReady),
        .aluValid(sAluValid), .aluAdr(sAluAdr), .aluData(sAluData), .aluReady(sAluReady),
        .writeAdr(sWriteAdr), .writeData(sWriteData), .writeEnable(sWriteEnable),
        .fwdAdr(sFwdAdr), .fwdHit(sFwdHit), .fwdData(sFwdData),
        .count(sCount), .full(sFull), .empty(sEmpty)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        mv;
        logic [5:0]  ma;
        logic [63:0] md;
        logic        av;
        logic [5:0]  aa;
        logic [63:0] ad;
        logic [5:0]  fa;
        logic        mr, ar;
        logic [2:0]  cnt;
        logic        we;
        logic [5:0]  wa;
        logic [63:0] wd;
        logic        hit;
        logic [63:0] fd;
    } vec_t;

    function automatic vec_t mk(
        input logic mv, input logic [5:0] ma, input logic [63:0] md,
        input logic av, input logic [5:0] aa, input logic [63:0] ad,
        input logic [5:0] fa, input logic mr, input logic ar,
        input logic [2:0] cnt, input logic we, input logic [5:0] wa,
        input logic [63:0] wd, input logic hit, input logic [63:0] fd);
        vec_t v;
        v.mv = mv; v.ma = ma; v.md = md; v.av = av; v.aa = aa; v.ad = ad;
        v.fa = fa; v.mr = mr; v.ar = ar; v.cnt = cnt; v.we = we; v.wa = wa;
        v.wd = wd; v.hit = hit; v.fd = fd;
        return v;
    endfunction

    vec_t vecs[$];

    // Random-traffic model state
    typedef struct { logic [5:0] a; logic [63:0] d; } ent_t;
    ent_t        q[$];
    ent_t        expOut;
    ent_t        e;
    bit          modelWe;
    logic        expMr, expAr, expHit;
    logic [63:0] expFd;
    logic [63:0] modelRf [8];
    logic [63:0] dutRf   [8];
    int          mc;

    initial begin
        // Expected values are sampled 1 time unit after the negedge drive,
        // i.e. they describe the state before the following rising edge.
        //            mv ma  md      av aa  ad       fa  mr ar cnt we wa  wd        hit fd
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      9,  1, 1, 0, 0, 0,  0,        0, 0));
        vecs.push_back(mk(0, 0,  0,     1, 5,  'h1234, 5,  1, 1, 0, 0, 0,  0,        0, 0));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      5,  1, 1, 1, 0, 0,  0,        1, 'h1234));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      5,  1, 1, 0, 1, 5,  'h1234,   1, 'h1234));
        vecs.push_back(mk(1, 3,  'hAA,  1, 3,  'hBB,   3,  1, 1, 0, 0, 5,  'h1234,   0, 0));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      3,  1, 1, 2, 0, 5,  'h1234,   1, 'hBB));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      3,  1, 1, 1, 1, 3,  'hAA,     1, 'hBB));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      3,  1, 1, 0, 1, 3,  'hBB,     1, 'hBB));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      3,  1, 1, 0, 0, 3,  'hBB,     0, 0));
        vecs.push_back(mk(1, 10, 'h10,  1, 11, 'h11,   9,  1, 1, 0, 0, 3,  'hBB,     0, 0));
        vecs.push_back(mk(1, 12, 'h12,  1, 13, 'h13,   9,  1, 1, 2, 0, 3,  'hBB,     0, 0));
        vecs.push_back(mk(1, 14, 'h14,  1, 15, 'h15,   13, 1, 0, 3, 1, 10, 'h10,     1, 'h13));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      12, 1, 1, 3, 1, 11, 'h11,     1, 'h12));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      11, 1, 1, 2, 1, 12, 'h12,     0, 0));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      14, 1, 1, 1, 1, 13, 'h13,     1, 'h14));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      0,  1, 1, 0, 1, 14, 'h14,     0, 0));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      14, 1, 1, 0, 0, 14, 'h14,     0, 0));
        vecs.push_back(mk(1, 0,  'h77,  0, 0,  0,      0,  1, 1, 0, 0, 14, 'h14,     0, 0));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      0,  1, 1, 1, 0, 14, 'h14,     1, 'h77));
        vecs.push_back(mk(0, 0,  0,     0, 0,  0,      0,  1, 1, 0, 1, 0,  'h77,     1, 'h77));

        // Reset both instances for two edges
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            if (i != 0) @(negedge clk);
            memValid = v.mv; memAdr = v.ma; memData = v.md;
            aluValid = v.av; aluAdr = v.aa; aluData = v.ad;
            fwdAdr   = v.fa;
            #1;
            chk($sformatf("v%0d.memReady", i), 64'(memReady), 64'(v.mr));
            chk($sformatf("v%0d.aluReady", i), 64'(aluReady), 64'(v.ar));
            chk($sformatf("v%0d.count", i), 64'(count), 64'(v.cnt));
            chk($sformatf("v%0d.empty", i), 64'(empty), 64'(v.cnt == 3'd0));
            chk($sformatf("v%0d.full", i), 64'(full), 64'(v.cnt == 3'd4));
            chk($sformatf("v%0d.writeEnable", i), 64'(writeEnable), 64'(v.we));
            chk($sformatf("v%0d.writeAdr", i), 64'(writeAdr), 64'(v.wa));
            chk($sformatf("v%0d.writeData", i), writeData, v.wd);
            chk($sformatf("v%0d.fwdHit", i), 64'(fwdHit), 64'(v.hit));
            chk($sformatf("v%0d.fwdData", i), fwdData, v.fd);
            $display("vector %0d: cnt=%0d we=%0b wa=%0d wd=%0h hit=%0b fd=%0h",
                     i, count, writeEnable, writeAdr, writeData, fwdHit, fwdData);
        end

        // ---------------- mid-operation reset with 3 entries queued --------
        @(negedge clk);
        memValid = 1; memAdr = 20; memData = 'h20;
        aluValid = 1; aluAdr = 21; aluData = 'h21;
        #1 chk("rst.pre0.count", 64'(count), 0);
        @(negedge clk);
        memAdr = 22; memData = 'h22; aluAdr = 23; aluData = 'h23;
        #1 chk("rst.pre1.count", 64'(count), 2);
        @(negedge clk);
        memValid = 0; aluValid = 0; resetN = 1'b0;
        #1;
        chk("rst.queued.count", 64'(count), 3);
        chk("rst.memReadyLow", 64'(memReady), 0);
        chk("rst.aluReadyLow", 64'(aluReady), 0);
        @(negedge clk);
        resetN = 1'b1; fwdAdr = 22;
        #1;
        chk("rst.count", 64'(count), 0);
        chk("rst.writeEnable", 64'(writeEnable), 0);
        chk("rst.writeAdr", 64'(writeAdr), 0);
        chk("rst.writeData", writeData, 0);
        chk("rst.memReady", 64'(memReady), 1);
        chk("rst.aluReady", 64'(aluReady), 1);
        chk("rst.empty", 64'(empty), 1);
        chk("rst.full", 64'(full), 0);
        chk("rst.fwdHit", 64'(fwdHit), 0);
        chk("rst.fwdData", fwdData, 0);
        $display("reset: cnt=%0d we=%0b", count, writeEnable);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 chk($sformatf("rst.noCommit%0d", k), 64'(writeEnable), 0);
        end

        // ---------------- full condition on the DEPTH=2 instance ----------
        @(negedge clk);
        sResetN = 1'b1;
        #1;
        chk("s.resetCount", 64'(sCount), 0);
        chk("s.resetEmpty", 64'(sEmpty), 1);
        @(negedge clk);
        sMemValid = 1; sMemAdr = 1; sMemData = 'hA1;
        sAluValid = 1; sAluAdr = 2; sAluData = 'hA2;
        #1;
        chk("s.dual.memReady", 64'(sMemReady), 1);
        chk("s.dual.aluReady", 64'(sAluReady), 1);
        @(negedge clk);
        sMemAdr = 3; sMemData = 'hA3; sAluAdr = 4; sAluData = 'hA4;
        #1;
        chk("s.full.count", 64'(sCount), 2);
        chk("s.full.full", 64'(sFull), 1);
        chk("s.full.memReady", 64'(sMemReady), 0);
        chk("s.full.aluReady", 64'(sAluReady), 0);
        @(negedge clk);
        #1;
        chk("s.last.count", 64'(sCount), 1);
        chk("s.last.full", 64'(sFull), 0);
        chk("s.last.memReady", 64'(sMemReady), 1);
        chk("s.last.aluReady", 64'(sAluReady), 0);
        chk("s.commit1.adr", 64'(sWriteAdr), 1);
        chk("s.commit1.data", sWriteData, 'hA1);
        @(negedge clk);
        sMemValid = 0;
        #1;
        chk("s.aluOnly.aluReady", 64'(sAluReady), 1);
        chk("s.commit2.adr", 64'(sWriteAdr), 2);
        chk("s.commit2.data", sWriteData, 'hA2);
        @(negedge clk);
        sAluValid = 0;
        #1;
        chk("s.commit3.we", 64'(sWriteEnable), 1);
        chk("s.commit3.data", sWriteData, 'hA3);
        @(negedge clk);
        #1;
        chk("s.commit4.we", 64'(sWriteEnable), 1);
        chk("s.commit4.data", sWriteData, 'hA4);
        @(negedge clk);
        #1;
        chk("s.drain.we", 64'(sWriteEnable), 0);
        chk("s.drain.empty", 64'(sEmpty), 1);
        $display("depth2 sequence: cnt=%0d empty=%0b", sCount, sEmpty);

        // ---------------- random dual-producer traffic ----------------
        modelWe = 1'b0;
        for (int r = 0; r < 8; r++) begin
            modelRf[r] = '0;
            dutRf[r]   = '0;
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            memValid = (c < 280) ? 1'($urandom_range(0, 1)) : 1'b0;
            aluValid = (c < 280) ? 1'($urandom_range(0, 1)) : 1'b0;
            memAdr   = 6'($urandom_range(0, 7));
            aluAdr   = 6'($urandom_range(0, 7));
            memData  = {$urandom, $urandom};
            aluData  = {$urandom, $urandom};
            fwdAdr   = 6'($urandom_range(0, 7));
            #1;
            mc    = q.size();
            expMr = (mc < 4);
            expAr = (mc <= 2) || (mc == 3 && !memValid);
            chk($sformatf("rnd%0d.count", c), 64'(count), 64'(mc));
            chk($sformatf("rnd%0d.memReady", c), 64'(memReady), 64'(expMr));
            chk($sformatf("rnd%0d.aluReady", c), 64'(aluReady), 64'(expAr));
            chk($sformatf("rnd%0d.writeEnable", c), 64'(writeEnable), 64'(modelWe));
            if (modelWe) begin
                chk($sformatf("rnd%0d.writeAdr", c), 64'(writeAdr), 64'(expOut.a));
                chk($sformatf("rnd%0d.writeData", c), writeData, expOut.d);
                modelRf[expOut.a[2:0]] = expOut.d;
                $display("commit %0d: adr=%0d data=%0h", c, writeAdr, writeData);
            end
            if (writeEnable === 1'b1) dutRf[writeAdr[2:0]] = writeData;
            // Forwarding expectation: youngest queued match, else output stage
            expHit = modelWe && (expOut.a == fwdAdr);
            expFd  = expHit ? expOut.d : 64'd0;
            foreach (q[j]) begin
                if (q[j].a == fwdAdr) begin
                    expHit = 1'b1;
                    expFd  = q[j].d;
                end
            end
            chk($sformatf("rnd%0d.fwdHit", c), 64'(fwdHit), 64'(expHit));
            chk($sformatf("rnd%0d.fwdData", c), fwdData, expFd);
            // Advance the model across the coming edge: pop first, then push
            if (q.size() > 0) begin
                expOut  = q.pop_front();
                modelWe = 1'b1;
            end else begin
                modelWe = 1'b0;
            end
            if (memValid && expMr) begin
                e.a = memAdr; e.d = memData; q.push_back(e);
            end
            if (aluValid && expAr) begin
                e.a = aluAdr; e.d = aluData; q.push_back(e);
            end
        end
        for (int r = 0; r < 8; r++)
            chk($sformatf("regfile[%0d]", r), dutRf[r], modelRf[r]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
